enum_level_stepper: RTL and testbench

//  Command-driven walker over enum_types::level_e (E_NONE=0, E_LOW=10, E_MEDIUM=20,
//  E_HIGH=30, E_MAX=40). Executes multi-step next/prev walks (one member per cycle),

---
 rtl/enum_level_stepper.sv | 199 +++++++++++++++++++
 tb/tb_enum_level_stepper.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/enum_level_stepper.sv
// Command-driven walker over the five-member level enumeration (0/10/20/30/40).
// Performs multi-step next/prev walks one member per cycle, validated loads and resets to the first member.
module enum_level_stepper #(
  parameter bit WRAP_EN   = 1'b1,
  parameter int CNT_W     = 4,
  parameter int RESET_IDX = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [31:0]      cmd_load_val,
  output logic [31:0]      level_out,
  output logic [2:0]       level_idx,
  output logic [31:0]      num_vals_out,
  output logic             busy,
  output logic             done,
  output logic             wrap_evt,
  output logic             sat_evt,
  output logic             load_err
);

  typedef enum logic [31:0] {
    E_NONE   = 32'd0,
    E_LOW    = 32'd10,
    E_MEDIUM = 32'd20,
    E_HIGH   = 32'd30,
    E_MAX    = 32'd40
  } level_e;

  typedef enum logic [1:0] {
    OP_NEXT  = 2'b00,
    OP_PREV  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_FIRST = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DONE
  } state_e;

  localparam logic [2:0]  LAST_IDX = 3'd4;
  localparam logic [2:0]  RST_IDX  = 3'(RESET_IDX);
  localparam logic [31:0] NUM_VALS = 32'd5;

  function automatic level_e idx_to_level(input logic [2:0] idx);
    case (idx)
      3'd0:    return E_NONE;
      3'd1:    return E_LOW;
      3'd2:    return E_MEDIUM;
      3'd3:    return E_HIGH;
      3'd4:    return E_MAX;
      default: return E_NONE;
    endcase
  endfunction

  state_e           state;
  logic [CNT_W-1:0] rem;
  logic             dir;
  logic [2:0]       cur_idx;

  logic [2:0] step_idx;
  logic       step_wrap;
  logic       step_sat;
  logic       load_hit;
  logic [2:0] load_idx;

  assign level_idx    = cur_idx;
  assign num_vals_out = NUM_VALS;

  // One walk step from the current ordinal, plus membership lookup for loads.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    step_idx  = cur_idx;
    step_wrap = 1'b0;
    step_sat  = 1'b0;
    if (!dir) begin
      if (cur_idx == LAST_IDX) begin
        if (WRAP_EN) begin
          step_idx  = 3'd0;
          step_wrap = 1'b1;
        end else begin
          step_sat = 1'b1;
        end
      end else begin
        step_idx = cur_idx + 3'd1;
      end
    end else begin
      if (cur_idx == 3'd0) begin
        if (WRAP_EN) begin
          step_idx  = LAST_IDX;
          step_wrap = 1'b1;
        end else begin
          step_sat = 1'b1;
        end
      end else begin
        step_idx = cur_idx - 3'd1;
      end
    end

    load_hit = 1'b0;
    load_idx = cur_idx;
    for (int i = 0; i < 5; i++) begin
      if (cmd_load_val == idx_to_level(3'(i))) begin
        load_hit = 1'b1;
        load_idx = 3'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rem       <= '0;
      dir       <= 1'b0;
      cur_idx   <= RST_IDX;
      level_out <= idx_to_level(RST_IDX);
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap_evt  <= 1'b0;
      sat_evt   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      done     <= 1'b0;
      wrap_evt <= 1'b0;
      sat_evt  <= 1'b0;
      load_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (cmd_op)
              OP_NEXT, OP_PREV: begin
                if (cmd_count != '0) begin
                  rem   <= cmd_count;
                  dir   <= cmd_op[0];
                  state <= S_STEP;
                end else begin
                  done  <= 1'b1;
                  state <= S_DONE;
                end
              end
              OP_LOAD: begin
                if (load_hit) begin
                  cur_idx   <= load_idx;
                  level_out <= idx_to_level(load_idx);
                end else begin
                  load_err <= 1'b1;
                end
                done  <= 1'b1;
                state <= S_DONE;
              end
              default: begin
                cur_idx   <= RST_IDX;
                level_out <= idx_to_level(RST_IDX);
                done      <= 1'b1;
                state     <= S_DONE;
              end
            endcase
          end
        end

        S_STEP: begin
          cur_idx   <= step_idx;
          level_out <= idx_to_level(step_idx);
          wrap_evt  <= step_wrap;
          sat_evt   <= step_sat;
          rem       <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enum_level_stepper.sv
// Bench for enum_level_stepper: a wrapping and a saturating instance share one command stream
// and are compared cycle by cycle against an ordinal-arithmetic reference model.
module tb_enum_level_stepper;

  localparam int CNT_W = 4;
  localparam int VALS [5] = '{0, 10, 20, 30, 40};
  localparam logic [1:0] OP_NEXT = 2'b00, OP_PREV = 2'b01, OP_LOAD = 2'b10, OP_FIRST = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [31:0]      cmd_load_val;

  logic [1:0]        ready_o, busy_o, done_o, wrap_o, sat_o, err_o;
  logic [1:0][31:0]  lvl_o, num_o;
  logic [1:0][2:0]   idx_o;

  int n_tests = 0;
  int n_fail  = 0;
  int m_idx [2];
  bit dut_err [2];

  always #5 clk = ~clk;

  enum_level_stepper #(.WRAP_EN(1'b1), .CNT_W(CNT_W), .RESET_IDX(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_o[0]),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_load_val(cmd_load_val),
    .level_out(lvl_o[0]), .level_idx(idx_o[0]), .num_vals_out(num_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .wrap_evt(wrap_o[0]), .sat_evt(sat_o[0]),
    .load_err(err_o[0])
  );

  enum_level_stepper #(.WRAP_EN(1'b0), .CNT_W(CNT_W), .RESET_IDX(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_o[1]),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_load_val(cmd_load_val),
    .level_out(lvl_o[1]), .level_idx(idx_o[1]), .num_vals_out(num_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .wrap_evt(wrap_o[1]), .sat_evt(sat_o[1]),
    .load_err(err_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d ready", tag, d), 32'(ready_o[d]), 32'd1);
      check($sformatf("%s d%0d busy", tag, d), 32'(busy_o[d]), 32'd0);
      check($sformatf("%s d%0d done", tag, d), 32'(done_o[d]), 32'd0);
      check($sformatf("%s d%0d level", tag, d), lvl_o[d], 32'(VALS[m_idx[d]]));
      check($sformatf("%s d%0d idx", tag, d), 32'(idx_o[d]), 32'(m_idx[d]));
      check($sformatf("%s d%0d num", tag, d), num_o[d], 32'd5);
    end
  endtask

  // Issue one command and follow it cycle by cycle until done. hold keeps cmd_valid
  // asserted with junk command fields while the block is busy.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt,
                         input logic [31:0] val, input bit hold);
    int li [2][16];
    bit we [2][16];
    bit se [2][16];
    int done_k;
    bit err;
    int i;
    bit walk;

    walk   = (op == OP_NEXT || op == OP_PREV) && (cnt != 0);
    done_k = walk ? int'(cnt) : 0;
    err    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) begin
        li[d][k] = 0; we[d][k] = 1'b0; se[d][k] = 1'b0;
      end
      i = m_idx[d];
      if (walk) begin
        li[d][0] = i;
        for (int k = 1; k <= int'(cnt); k++) begin
          if (op == OP_NEXT) begin
            if (i == 4) begin
              if (d == 0) begin i = 0; we[d][k] = 1'b1; end
              else se[d][k] = 1'b1;
            end else i = i + 1;
          end else begin
            if (i == 0) begin
              if (d == 0) begin i = 4; we[d][k] = 1'b1; end
              else se[d][k] = 1'b1;
            end else i = i - 1;
          end
          li[d][k] = i;
        end
      end else begin
        if (op == OP_LOAD) begin
          err = 1'b1;
          for (int j = 0; j < 5; j++)
            if (val == 32'(VALS[j])) begin i = j; err = 1'b0; end
        end else if (op == OP_FIRST) begin
          i = 0;
        end
        li[d][0] = i;
      end
      m_idx[d] = i;
    end

    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("pre-accept d%0d ready", d), 32'(ready_o[d]), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_load_val = val;
    @(posedge clk);
    #1;
    if (hold) begin
      cmd_op = 2'($urandom); cmd_count = 4'($urandom); cmd_load_val = $urandom;
    end else begin
      cmd_valid = 1'b0;
    end

    for (int k = 0; k <= done_k; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("op%0d c%0d k%0d d%0d level", op, cnt, k, d), lvl_o[d], 32'(VALS[li[d][k]]));
        check($sformatf("op%0d c%0d k%0d d%0d idx", op, cnt, k, d), 32'(idx_o[d]), 32'(li[d][k]));
        check($sformatf("op%0d c%0d k%0d d%0d done", op, cnt, k, d), 32'(done_o[d]), 32'(k == done_k));
        check($sformatf("op%0d c%0d k%0d d%0d wrap", op, cnt, k, d), 32'(wrap_o[d]), 32'(we[d][k]));
        check($sformatf("op%0d c%0d k%0d d%0d sat", op, cnt, k, d), 32'(sat_o[d]), 32'(se[d][k]));
        check($sformatf("op%0d c%0d k%0d d%0d load_err", op, cnt, k, d), 32'(err_o[d]),
              32'(k == done_k && err));
        check($sformatf("op%0d c%0d k%0d d%0d busy", op, cnt, k, d), 32'(busy_o[d]), 32'd1);
        check($sformatf("op%0d c%0d k%0d d%0d ready", op, cnt, k, d), 32'(ready_o[d]), 32'd0);
        check($sformatf("op%0d c%0d k%0d d%0d num", op, cnt, k, d), num_o[d], 32'd5);
        if (k == done_k) dut_err[d] = err_o[d];
      end
      if (k == done_k) cmd_valid = 1'b0;
      else if (hold) begin
        cmd_op = 2'($urandom); cmd_count = 4'($urandom); cmd_load_val = $urandom;
      end
    end
    @(negedge clk);
    check_idle($sformatf("post op%0d c%0d", op, cnt));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic [31:0] val;
    logic [31:0] exp_w;
    logic [31:0] exp_s;
    bit          exp_err;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{OP_NEXT,  4'd3,  32'd0,          32'd30, 32'd30, 1'b0};
    tbl[1]  = '{OP_NEXT,  4'd3,  32'd0,          32'd10, 32'd40, 1'b0};
    tbl[2]  = '{OP_LOAD,  4'd0,  32'd10,         32'd10, 32'd10, 1'b0};
    tbl[3]  = '{OP_PREV,  4'd4,  32'd0,          32'd20, 32'd0,  1'b0};
    tbl[4]  = '{OP_LOAD,  4'd0,  32'd20,         32'd20, 32'd20, 1'b0};
    tbl[5]  = '{OP_LOAD,  4'd0,  32'd25,         32'd20, 32'd20, 1'b1};
    tbl[6]  = '{OP_NEXT,  4'd0,  32'd0,          32'd20, 32'd20, 1'b0};
    tbl[7]  = '{OP_FIRST, 4'd0,  32'd0,          32'd0,  32'd0,  1'b0};
    tbl[8]  = '{OP_PREV,  4'd1,  32'd0,          32'd40, 32'd0,  1'b0};
    tbl[9]  = '{OP_LOAD,  4'd0,  32'hFFFF_FFFF,  32'd40, 32'd0,  1'b1};
    tbl[10] = '{OP_LOAD,  4'd0,  32'd40,         32'd40, 32'd40, 1'b0};
    tbl[11] = '{OP_NEXT,  4'd15, 32'd0,          32'd40, 32'd40, 1'b0};
    tbl[12] = '{OP_PREV,  4'd0,  32'd0,          32'd40, 32'd40, 1'b0};
    tbl[13] = '{OP_LOAD,  4'd0,  32'd30,         32'd30, 32'd30, 1'b0};
    tbl[14] = '{OP_PREV,  4'd2,  32'd0,          32'd10, 32'd10, 1'b0};

    m_idx[0] = 0; m_idx[1] = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0; cmd_load_val = '0;
    repeat (3) @(negedge clk);
    check_idle("in reset");
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset d%0d wrap", d), 32'(wrap_o[d]), 32'd0);
      check($sformatf("reset d%0d sat", d), 32'(sat_o[d]), 32'd0);
      check($sformatf("reset d%0d load_err", d), 32'(err_o[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after reset");

    for (int v = 0; v < 15; v++) begin
      run_cmd(tbl[v].op, tbl[v].cnt, tbl[v].val, 1'b0);
      check($sformatf("vec%0d wrap final level", v), lvl_o[0], tbl[v].exp_w);
      check($sformatf("vec%0d sat final level", v), lvl_o[1], tbl[v].exp_s);
      check($sformatf("vec%0d wrap load_err", v), 32'(dut_err[0]), 32'(tbl[v].exp_err));
      check($sformatf("vec%0d sat load_err", v), 32'(dut_err[1]), 32'(tbl[v].exp_err));
    end

    // Reset in the middle of a 15-step walk aborts it without a done pulse.
    run_cmd(OP_FIRST, 4'd0, 32'd0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_NEXT; cmd_count = 4'd15;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("mid-walk d%0d level", d), lvl_o[d], 32'd40);
    rst_n = 1'b0;
    #1;
    m_idx[0] = 0; m_idx[1] = 0;
    check_idle("async abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("after abort");
    end

    for (int r = 0; r < 60; r++) begin
      logic [1:0]  op;
      logic [3:0]  cnt;
      logic [31:0] val;
      op  = 2'($urandom_range(0, 3));
      cnt = 4'($urandom_range(0, 15));
      val = ($urandom_range(0, 1) == 1) ? 32'(VALS[$urandom_range(0, 4)]) : $urandom;
      run_cmd(op, cnt, val, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
